apb_rmw_master: RTL and testbench
=================================

Name: apb_rmw_master

Overview:
Parametrised APB master that executes one command at a time from a valid/ready command port: READ, WRITE, or atomic read-modify-write ADD to any address. It generalises the fixed-address increment master with configurable address/data width, a per-command operand and target address, PSLVERR handling, and an ACCESS-phase timeout. It sits between a local controller and a single APB slave segment.

Parameters:
ADDR_W, 32, APB address width
DATA_W, 32, APB data width
TIMEOUT, 16, max ACCESS-phase cycles waiting for pready_i; 0 disables timeout

Ports:
pclk  in  1  APB clock
preset_n  in  1  reset, asynchronous, active-low
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command accepted when valid&ready
cmd_op_i  in  2  2'b00 NOP, 2'b01 READ, 2'b10 WRITE, 2'b11 RMW_ADD
cmd_addr_i  in  ADDR_W  target address
cmd_data_i  in  DATA_W  write data (WRITE) or addend (RMW_ADD)
psel_o  out  1  APB select
penable_o  out  1  APB enable
paddr_o  out  ADDR_W  APB address
pwrite_o  out  1  APB direction
pwdata_o  out  DATA_W  APB write data
prdata_i  in  DATA_W  APB read data
pready_i  in  1  APB ready
pslverr_i  in  1  APB slave error
rsp_valid_o  out  1  one-cycle response pulse, no backpressure
rsp_data_o  out  DATA_W  READ: read data; RMW_ADD: value written; WRITE: 0
rsp_err_o  out  1  PSLVERR or timeout on the command
rsp_timeout_o  out  1  error caused by timeout

Behaviour:
- Clock pclk; reset preset_n, asynchronous, active-low. All outputs registered; reset: psel/penable/pwrite/rsp_* = 0, paddr/pwdata = 0, cmd_ready_o = 1 (state IDLE).
- States: IDLE, SETUP, ACCESS. A phase flag marks the RMW write leg.
- IDLE: cmd_ready_o=1. NOP accepted, no APB activity, no response. READ/WRITE/RMW: latch op, addr, data; next cycle SETUP.
- SETUP (1 cycle): psel=1, penable=0, paddr=addr, pwrite=1 for WRITE or RMW write leg, else 0; pwdata valid when writing, 0 when reading. Next ACCESS.
- ACCESS: psel=1, penable=1; paddr/pwrite/pwdata held stable. Timeout counter increments each ACCESS cycle with pready_i=0.
- pready_i=1 in ACCESS:
  - READ, or WRITE, or RMW write leg: capture prdata_i (reads only); the next cycle has rsp_valid_o=1, returns to IDLE, and deasserts psel.
  - RMW read leg with pslverr_i=0: sum = prdata_i + addend (mod 2^DATA_W, carry dropped); go directly to SETUP for the write leg. psel stays 1 and penable drops, which is legal back-to-back APB. Same address.
  - RMW read leg with pslverr_i=1: no write leg. Respond with rsp_err_o=1, rsp_data_o=0.
- pslverr_i is sampled only when penable&pready; a final-leg error sets rsp_err_o. READ error still returns prdata_i.
- Timeout (TIMEOUT!=0): at TIMEOUT cycles waiting, abort. psel/penable go to 0 next cycle with rsp_valid_o=1, rsp_err_o=1, rsp_timeout_o=1, rsp_data_o=0; return to IDLE. An RMW aborted in its read leg issues no write. The counter clears on every SETUP.
- Latency (no wait states): READ/WRITE accept at edge 0, SETUP at cycle 1, ACCESS at cycle 2, rsp_valid_o at cycle 3 with cmd_ready_o=1 again. RMW_ADD: rsp_valid_o at cycle 5.
- cmd_ready_o=0 outside IDLE. cmd_* are ignored while busy.
- Reset mid-transfer: immediate return to reset values. No response is issued for the lost command.

Decomposition:
- Package apb_rmw_pkg holds apb_state_t (ST_IDLE, ST_SETUP, ST_ACCESS) and cmd_op_t (OP_NOP, OP_READ, OP_WRITE, OP_RMW_ADD) as logic[1:0] enums.
- One sub-module, apb_timeout_cnt: parametrised by TIMEOUT, with clear, enable and expired inputs/outputs; when TIMEOUT=0 it ties expired to 0.

Test Plan:
- READ 0x0000_A000, slave returns 0x0000_0041 with 0 waits -> SETUP cycle 1, ACCESS cycle 2, rsp_valid_o at cycle 3 with rsp_data_o=0x41, rsp_err_o=0.
- WRITE 0x10 data 0xDEAD_BEEF with 3 wait states -> pwdata/paddr stable for 4 ACCESS cycles, single response, rsp_data_o=0.
- RMW_ADD 0xA000 addend 1, slave holds 0xFFFF_FFFF -> read leg, then write leg pwdata=0x0000_0000 (wrap), rsp_data_o=0, psel held high across both legs.
- RMW_ADD where the read leg returns pslverr_i=1 -> no write leg (pwrite_o never 1), rsp_err_o=1, rsp_timeout_o=0.
- TIMEOUT=16, slave never asserts pready -> abort after 16 ACCESS cycles, rsp_err_o=1, rsp_timeout_o=1, psel_o=0, cmd_ready_o=1.
- Assert preset_n low during RMW write-leg ACCESS -> all outputs 0 and cmd_ready_o=1 immediately, no rsp_valid_o; the next READ completes normally.

Source files
------------

// File: rtl/apb_rmw_master_pkg.sv
// Shared types for the APB read-modify-write master: FSM states and command opcodes.
package apb_rmw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10
  } apb_state_t;

  typedef enum logic [1:0] {
    OP_NOP     = 2'b00,
    OP_READ    = 2'b01,
    OP_WRITE   = 2'b10,
    OP_RMW_ADD = 2'b11
  } cmd_op_t;

endpackage

// File: rtl/apb_rmw_master_if.sv
// Command, APB and response signals of the APB read-modify-write master.
// The master modport is the master's own view; slave is the environment's view.
interface apb_rmw_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic [1:0]        cmd_op_i;
  logic [ADDR_W-1:0] cmd_addr_i;
  logic [DATA_W-1:0] cmd_data_i;

  logic              psel_o;
  logic              penable_o;
  logic [ADDR_W-1:0] paddr_o;
  logic              pwrite_o;
  logic [DATA_W-1:0] pwdata_o;
  logic [DATA_W-1:0] prdata_i;
  logic              pready_i;
  logic              pslverr_i;

  logic              rsp_valid_o;
  logic [DATA_W-1:0] rsp_data_o;
  logic              rsp_err_o;
  logic              rsp_timeout_o;

  modport master (
    input  cmd_valid_i, cmd_op_i, cmd_addr_i, cmd_data_i,
    input  prdata_i, pready_i, pslverr_i,
    output cmd_ready_o,
    output psel_o, penable_o, paddr_o, pwrite_o, pwdata_o,
    output rsp_valid_o, rsp_data_o, rsp_err_o, rsp_timeout_o
  );

  modport slave (
    output cmd_valid_i, cmd_op_i, cmd_addr_i, cmd_data_i,
    output prdata_i, pready_i, pslverr_i,
    input  cmd_ready_o,
    input  psel_o, penable_o, paddr_o, pwrite_o, pwdata_o,
    input  rsp_valid_o, rsp_data_o, rsp_err_o, rsp_timeout_o
  );

endinterface

// File: rtl/apb_rmw_master_timeout_cnt.sv
// ACCESS-phase wait counter. expired_o flags the TIMEOUT-th consecutive waiting
// cycle so the master can abort on that same edge. TIMEOUT=0 disables it.
module apb_timeout_cnt #(
  parameter int TIMEOUT = 16
) (
  input  logic pclk,
  input  logic preset_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  if (TIMEOUT == 0) begin : g_off
    logic unused_inputs;
    assign unused_inputs = clear_i ^ enable_i ^ pclk ^ preset_n;
    assign expired_o     = 1'b0;
  end else begin : g_on
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count waiting cycles, saturating at TIMEOUT; cleared at every SETUP.
    always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
        cnt_d = '0;
      end else if (enable_i && (cnt_q != CW'(TIMEOUT))) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Counter register.
    always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign expired_o = enable_i && (cnt_q == CW'(TIMEOUT - 1));
  end

endmodule

// File: rtl/apb_rmw_master.sv
// APB master executing one READ, WRITE or atomic read-modify-write ADD at a time.
// The RMW write leg follows the read leg back-to-back with psel held high.
module apb_rmw_master
  import apb_rmw_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            pclk,
  input  logic            preset_n,
  apb_rmw_master_if.master bus
);

  apb_state_t        state_q;
  cmd_op_t           op_q;
  logic              rmw_wr_q;
  logic [DATA_W-1:0] data_q;

  logic              cmd_ready_q;
  logic              psel_q;
  logic              penable_q;
  logic [ADDR_W-1:0] paddr_q;
  logic              pwrite_q;
  logic [DATA_W-1:0] pwdata_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_err_q;
  logic              rsp_timeout_q;

  cmd_op_t           op_in;
  logic              tmo_clear;
  logic              tmo_enable;
  logic              tmo_expired;
  logic [DATA_W-1:0] rmw_sum;

  // Modulo-2^DATA_W addition; the carry out is intentionally discarded.
  function automatic logic [DATA_W-1:0] add_wrap(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    return a + b;
  endfunction

  assign op_in      = cmd_op_t'(bus.cmd_op_i);
  assign rmw_sum    = add_wrap(bus.prdata_i, data_q);
  assign tmo_clear  = (state_q == ST_SETUP);
  assign tmo_enable = (state_q == ST_ACCESS) && !bus.pready_i;

  apb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .pclk      (pclk),
    .preset_n  (preset_n),
    .clear_i   (tmo_clear),
    .enable_i  (tmo_enable),
    .expired_o (tmo_expired)
  );

  // Command/APB/response FSM with all outputs registered.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q       <= ST_IDLE;
      op_q          <= OP_NOP;
      rmw_wr_q      <= 1'b0;
      data_q        <= '0;
      cmd_ready_q   <= 1'b1;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          // NOP is consumed here without touching the bus.
          if (bus.cmd_valid_i && (op_in != OP_NOP)) begin
            op_q        <= op_in;
            data_q      <= bus.cmd_data_i;
            rmw_wr_q    <= 1'b0;
            paddr_q     <= bus.cmd_addr_i;
            psel_q      <= 1'b1;
            penable_q   <= 1'b0;
            pwrite_q    <= (op_in == OP_WRITE);
            pwdata_q    <= (op_in == OP_WRITE) ? bus.cmd_data_i : '0;
            cmd_ready_q <= 1'b0;
            state_q     <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ST_ACCESS;
        end

        ST_ACCESS: begin
          if (bus.pready_i) begin
            if ((op_q == OP_RMW_ADD) && !rmw_wr_q && !bus.pslverr_i) begin
              // Read leg done: turn straight into the write leg at the same address.
              data_q    <= rmw_sum;
              pwdata_q  <= rmw_sum;
              pwrite_q  <= 1'b1;
              penable_q <= 1'b0;
              rmw_wr_q  <= 1'b1;
              state_q   <= ST_SETUP;
            end else begin
              psel_q      <= 1'b0;
              penable_q   <= 1'b0;
              pwrite_q    <= 1'b0;
              pwdata_q    <= '0;
              rmw_wr_q    <= 1'b0;
              cmd_ready_q <= 1'b1;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= bus.pslverr_i;
              if (op_q == OP_READ) begin
                rsp_data_q <= bus.prdata_i;
              end else if ((op_q == OP_RMW_ADD) && rmw_wr_q) begin
                rsp_data_q <= data_q;
              end
              state_q <= ST_IDLE;
            end
          end else if (tmo_expired) begin
            // Slave never answered: abandon the command, no write leg follows.
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            rmw_wr_q      <= 1'b0;
            cmd_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b1;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            state_q       <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready_o   = cmd_ready_q;
  assign bus.psel_o        = psel_q;
  assign bus.penable_o     = penable_q;
  assign bus.paddr_o       = paddr_q;
  assign bus.pwrite_o      = pwrite_q;
  assign bus.pwdata_o      = pwdata_q;
  assign bus.rsp_valid_o   = rsp_valid_q;
  assign bus.rsp_data_o    = rsp_data_q;
  assign bus.rsp_err_o     = rsp_err_q;
  assign bus.rsp_timeout_o = rsp_timeout_q;

endmodule

// File: tb/tb_apb_rmw_master.sv
// Directed bench for apb_rmw_master with a configurable single-slave model.
module tb_apb_rmw_master;

  logic pclk;
  logic preset_n;

  apb_rmw_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb_rmw_master #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (16)
  ) dut (
    .pclk     (pclk),
    .preset_n (preset_n),
    .bus      (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int n_chk;
  int n_bad;

  // slave configuration
  int          wait_cfg;
  logic [31:0] mem_val;
  bit          err_rd;
  bit          hang;
  int          acc_cnt;

  // per-transaction observations filled by wait_rsp
  int          lat;
  int          acc_cycles;
  int          wr_cycles;
  int          psel_drops;
  int          addr_bad;
  int          wdata_bad;
  logic [31:0] wr_last;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Slave: decides pready/prdata/pslverr for each ACCESS cycle at the falling edge.
  always @(negedge pclk) begin
    if (bus.psel_o && bus.penable_o) begin
      bus.pready_i  = !hang && (acc_cnt == wait_cfg);
      bus.prdata_i  = bus.pwrite_o ? 32'h0 : mem_val;
      bus.pslverr_i = err_rd && !bus.pwrite_o && (acc_cnt == wait_cfg);
      acc_cnt++;
    end else begin
      bus.pready_i  = 1'b0;
      bus.prdata_i  = 32'h0;
      bus.pslverr_i = 1'b0;
      acc_cnt       = 0;
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_op_i    = op;
    bus.cmd_addr_i  = addr;
    bus.cmd_data_i  = data;
    @(posedge pclk);
    #1;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_op_i    = 2'b00;
  endtask

  // Step falling edges until rsp_valid_o, recording bus activity along the way.
  task automatic wait_rsp(input string tag, input int max_cyc, input logic [31:0] exp_addr,
                          input logic [31:0] exp_wdata);
    bit seen;
    seen = 0;
    lat = 0; acc_cycles = 0; wr_cycles = 0; psel_drops = 0;
    addr_bad = 0; wdata_bad = 0; wr_last = 32'hx;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge pclk);
      if (bus.rsp_valid_o) begin
        lat  = i;
        seen = 1;
        break;
      end
      if (!bus.psel_o) psel_drops++;
      if (bus.psel_o && bus.paddr_o !== exp_addr) addr_bad++;
      if (bus.psel_o && bus.penable_o) acc_cycles++;
      if (bus.psel_o && bus.pwrite_o) begin
        wr_cycles++;
        wr_last = bus.pwdata_o;
        if (bus.pwdata_o !== exp_wdata) wdata_bad++;
      end
    end
    if (!seen) check_val({tag, "_rsp_seen"}, 0, 1);
  endtask

  initial begin
    n_chk = 0; n_bad = 0;
    wait_cfg = 0; mem_val = 32'h0; err_rd = 0; hang = 0; acc_cnt = 0;
    bus.cmd_valid_i = 1'b0; bus.cmd_op_i = 2'b00;
    bus.cmd_addr_i = '0; bus.cmd_data_i = '0;
    bus.pready_i = 1'b0; bus.prdata_i = '0; bus.pslverr_i = 1'b0;
    preset_n = 1'b0;
    repeat (3) @(negedge pclk);
    check_val("rst_ready", bus.cmd_ready_o, 1);
    check_val("rst_psel", {bus.psel_o, bus.penable_o, bus.pwrite_o}, 0);
    check_val("rst_addr_wdata", {bus.paddr_o, bus.pwdata_o}, 0);
    check_val("rst_rsp", {bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_timeout_o}, 0);
    preset_n = 1'b1;
    @(negedge pclk);

    // NOP: no bus activity, no response
    issue(2'b00, 32'h1234, 32'h1);
    repeat (3) begin
      @(negedge pclk);
      check_val("nop_quiet", {bus.psel_o, bus.rsp_valid_o, bus.cmd_ready_o}, 3'b001);
    end

    // READ with zero waits, cycle-exact
    mem_val = 32'h0000_0041; wait_cfg = 0;
    issue(2'b01, 32'h0000_A000, 32'h0);
    @(negedge pclk);
    check_val("rd_setup", {bus.psel_o, bus.penable_o, bus.pwrite_o, bus.cmd_ready_o}, 4'b1000);
    check_val("rd_setup_addr", bus.paddr_o, 32'h0000_A000);
    check_val("rd_setup_wdata", bus.pwdata_o, 0);
    @(negedge pclk);
    check_val("rd_access", {bus.psel_o, bus.penable_o, bus.rsp_valid_o}, 3'b110);
    @(negedge pclk);
    check_val("rd_rsp", {bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_timeout_o}, 3'b100);
    check_val("rd_data", bus.rsp_data_o, 32'h41);
    check_val("rd_idle", {bus.psel_o, bus.penable_o, bus.cmd_ready_o}, 3'b001);
    @(negedge pclk);
    check_val("rd_pulse", bus.rsp_valid_o, 0);

    // WRITE with three wait states
    wait_cfg = 3;
    issue(2'b10, 32'h10, 32'hDEAD_BEEF);
    wait_rsp("wr", 40, 32'h10, 32'hDEAD_BEEF);
    check_val("wr_lat", lat, 6);
    check_val("wr_acc", acc_cycles, 4);
    check_val("wr_stable", {addr_bad, wdata_bad}, 0);
    check_val("wr_wcyc", wr_cycles, 5);
    check_val("wr_rsp", {bus.rsp_err_o, bus.rsp_timeout_o, bus.rsp_data_o}, 0);
    @(negedge pclk);
    check_val("wr_single", bus.rsp_valid_o, 0);

    // RMW_ADD with wrap-around
    wait_cfg = 0; mem_val = 32'hFFFF_FFFF;
    issue(2'b11, 32'h0000_A000, 32'h1);
    wait_rsp("rmw", 40, 32'h0000_A000, 32'h0);
    check_val("rmw_lat", lat, 5);
    check_val("rmw_psel_held", psel_drops, 0);
    check_val("rmw_wcyc", wr_cycles, 2);
    check_val("rmw_wdata", {wdata_bad, wr_last}, 0);
    check_val("rmw_rsp", {bus.rsp_err_o, bus.rsp_timeout_o, bus.rsp_data_o}, 0);

    // RMW_ADD without wrap, one wait state per leg
    wait_cfg = 1; mem_val = 32'h0000_0041;
    issue(2'b11, 32'h0000_0200, 32'h0000_0100);
    wait_rsp("rmw2", 40, 32'h0000_0200, 32'h0000_0141);
    check_val("rmw2_lat", lat, 7);
    check_val("rmw2_acc", acc_cycles, 4);
    check_val("rmw2_wdata", wr_last, 32'h141);
    check_val("rmw2_data", bus.rsp_data_o, 32'h141);
    check_val("rmw2_err", bus.rsp_err_o, 0);

    // RMW_ADD whose read leg errors: no write leg
    wait_cfg = 0; mem_val = 32'h0000_0055; err_rd = 1;
    issue(2'b11, 32'h0000_0300, 32'h1);
    wait_rsp("rmwerr", 40, 32'h0000_0300, 32'h0);
    check_val("rmwerr_lat", lat, 3);
    check_val("rmwerr_nowrite", wr_cycles, 0);
    check_val("rmwerr_rsp", {bus.rsp_err_o, bus.rsp_timeout_o}, 2'b10);
    check_val("rmwerr_data", bus.rsp_data_o, 0);

    // READ with slave error still returns data
    issue(2'b01, 32'h0000_0400, 32'h0);
    wait_rsp("rderr", 40, 32'h0000_0400, 32'h0);
    check_val("rderr_rsp", {bus.rsp_err_o, bus.rsp_timeout_o}, 2'b10);
    check_val("rderr_data", bus.rsp_data_o, 32'h55);
    err_rd = 0;

    // Timeout on a slave that never answers
    hang = 1; mem_val = 32'h0000_0077;
    issue(2'b11, 32'h0000_0500, 32'h1);
    wait_rsp("tmo", 60, 32'h0000_0500, 32'h0);
    check_val("tmo_acc", acc_cycles, 16);
    check_val("tmo_lat", lat, 18);
    check_val("tmo_nowrite", wr_cycles, 0);
    check_val("tmo_rsp", {bus.rsp_err_o, bus.rsp_timeout_o, bus.rsp_data_o}, {2'b11, 32'h0});
    check_val("tmo_idle", {bus.psel_o, bus.penable_o, bus.cmd_ready_o}, 3'b001);
    hang = 0;

    // Reset during the RMW write-leg ACCESS
    wait_cfg = 2; mem_val = 32'h5;
    issue(2'b11, 32'h0000_0600, 32'h2);
    begin
      bit hit;
      hit = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge pclk);
        if (bus.psel_o && bus.penable_o && bus.pwrite_o) begin
          hit = 1;
          break;
        end
      end
      check_val("rst_mid_reached", hit, 1);
    end
    preset_n = 1'b0;
    #1;
    check_val("rst_mid_bus", {bus.psel_o, bus.penable_o, bus.pwrite_o}, 0);
    check_val("rst_mid_regs", {bus.paddr_o, bus.pwdata_o}, 0);
    check_val("rst_mid_ready", {bus.cmd_ready_o, bus.rsp_valid_o}, 2'b10);
    repeat (2) begin
      @(negedge pclk);
      check_val("rst_mid_norsp", bus.rsp_valid_o, 0);
    end
    preset_n = 1'b1;
    @(negedge pclk);
    check_val("rst_mid_norsp2", bus.rsp_valid_o, 0);

    // Normal READ after the reset
    wait_cfg = 0; mem_val = 32'h0000_0041;
    issue(2'b01, 32'h0000_A000, 32'h0);
    wait_rsp("rd2", 40, 32'h0000_A000, 32'h0);
    check_val("rd2_lat", lat, 3);
    check_val("rd2_data", {bus.rsp_err_o, bus.rsp_data_o}, {1'b0, 32'h41});

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
